// File: rtl/rvvi_rx_packer.sv
// rvvi_rx_packer: packs MAC receive bytes little-endian into 32-bit RVVI words,
// truncates over-length frames, flags errored frames and keeps frame/error counts.
module rvvi_rx_packer #(
   parameter int unsigned MAX_WORDS = 384,
   parameter int unsigned CNTW      = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [7:0]      RxTdata,
   input  logic            RxTvalid,
   input  logic            RxTlast,
   input  logic            RxTuser,
   output logic [31:0]     RvviAxiRdata,
   output logic [3:0]      RvviAxiRstrb,
   output logic            RvviAxiRlast,
   output logic            RvviAxiRuser,
   output logic            RvviAxiRvalid,
   output logic [CNTW-1:0] FrameCount,
   output logic [CNTW-1:0] ErrorCount
);

   localparam int unsigned WCW = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PACK    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t         state;
   logic [31:0]    acc;
   logic [1:0]     byteIdx;
   logic [WCW-1:0] wordCount;

   logic [31:0]    merged_c;
   logic [3:0]     strb_c;
   logic           emit_c;
   logic           trunc_c;
   logic           frameEnd_c;
   logic           user_c;

   // Merge the incoming byte into its lane and decide whether a word goes out.
   always_comb begin
      merged_c   = acc | (32'(RxTdata) << {byteIdx, 3'b000});
      strb_c     = 4'b0001;
      case (byteIdx)
         2'd0:    strb_c = 4'b0001;
         2'd1:    strb_c = 4'b0011;
         2'd2:    strb_c = 4'b0111;
         default: strb_c = 4'b1111;
      endcase
      emit_c     = RxTvalid && (state != DISCARD) && (RxTlast || (byteIdx == 2'd3));
      // The word numbered MAX_WORDS without a natural end cuts the frame short.
      trunc_c    = emit_c && !RxTlast && (wordCount == WCW'(MAX_WORDS - 1));
      frameEnd_c = emit_c && (RxTlast || trunc_c);
      user_c     = RxTlast ? RxTuser : trunc_c;
   end

   // Packing state machine, registered word outputs and saturating statistics.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         acc           <= '0;
         byteIdx       <= '0;
         wordCount     <= '0;
         RvviAxiRdata  <= '0;
         RvviAxiRstrb  <= '0;
         RvviAxiRlast  <= 1'b0;
         RvviAxiRuser  <= 1'b0;
         RvviAxiRvalid <= 1'b0;
         FrameCount    <= '0;
         ErrorCount    <= '0;
      end else begin
         RvviAxiRvalid <= 1'b0;
         if (emit_c) begin
            RvviAxiRdata  <= merged_c;
            RvviAxiRstrb  <= strb_c;
            RvviAxiRlast  <= frameEnd_c;
            RvviAxiRuser  <= user_c;
            RvviAxiRvalid <= 1'b1;
            acc           <= '0;
            byteIdx       <= '0;
            wordCount     <= frameEnd_c ? '0 : wordCount + WCW'(1);
            if (frameEnd_c) begin
               if (FrameCount != {CNTW{1'b1}}) FrameCount <= FrameCount + CNTW'(1);
               if (user_c && (ErrorCount != {CNTW{1'b1}})) ErrorCount <= ErrorCount + CNTW'(1);
            end
            if (trunc_c)      state <= DISCARD;
            else if (RxTlast) state <= IDLE;
            else              state <= PACK;
         end else if (RxTvalid) begin
            case (state)
               IDLE, PACK: begin
                  acc     <= merged_c;
                  byteIdx <= byteIdx + 2'd1;
                  state   <= PACK;
               end
               DISCARD: begin
                  if (RxTlast) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
